sin_lut_nco_ctrl: RTL and testbench

//  Sequencer for the single-port-write / combinational-read sine LUT.
//  - Loads the LUT from a host valid/ready stream at addresses 0..NUM_ENTRY-1.
//  - Runs a phase accumulator (NCO) that addresses the LUT every cycle.
//  - Registers the returned sample and drives it to the pulse datapath.
//  - Sits between the host/config interface and the LUT instance.

---
 rtl/sin_lut_nco_ctrl.sv | 143 ++++++++++++++
 tb/tb_sin_lut_nco_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/sin_lut_nco_ctrl.sv
// Sine LUT sequencer: loads the table from a valid/ready stream, then sweeps it with a phase
// accumulator. Define SIN_LUT_CTRL_PHASE_OFFSET_EN to add the phase_offset input to the phase.
module sin_lut_nco_ctrl #(
  parameter int unsigned NUM_ENTRY   = 1024,
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned PHASE_WIDTH = 24
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ld_start,
  input  logic                   ld_valid,
  input  logic [DATA_WIDTH-1:0]  ld_data,
  output logic                   ld_ready,
  output logic                   lut_loaded,
  input  logic                   run_en,
  input  logic [PHASE_WIDTH-1:0] freq_word,
`ifdef SIN_LUT_CTRL_PHASE_OFFSET_EN
  input  logic [PHASE_WIDTH-1:0] phase_offset,
`endif
  output logic                   lut_wr_en,
  output logic [ADDR_WIDTH-1:0]  lut_wr_addr,
  output logic [DATA_WIDTH-1:0]  lut_wr_data,
  output logic [ADDR_WIDTH-1:0]  lut_rd_addr,
  input  logic [DATA_WIDTH-1:0]  lut_rd_data,
  output logic [DATA_WIDTH-1:0]  sample_out,
  output logic                   sample_valid,
  output logic                   busy
);

  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(NUM_ENTRY - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StRun} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic                    loaded_q, loaded_d;
  logic                    wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
  logic [PHASE_WIDTH-1:0]  acc_q, acc_d;
  logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
  logic                    addr_vld_q, addr_vld_d;
  logic [DATA_WIDTH-1:0]   sample_q, sample_d;
  logic                    sample_vld_q, sample_vld_d;
  logic [PHASE_WIDTH-1:0]  phase;

`ifdef SIN_LUT_CTRL_PHASE_OFFSET_EN
  assign phase = acc_q + phase_offset;
`else
  assign phase = acc_q;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    loaded_d     = loaded_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    acc_d        = acc_q;
    rd_addr_d    = rd_addr_q;
    addr_vld_d   = 1'b0;
    sample_d     = sample_q;
    sample_vld_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        acc_d = '0;
        if (ld_start) begin
          state_d  = StLoad;
          cnt_d    = '0;
          loaded_d = 1'b0;
        end else if (run_en && loaded_q) begin
          state_d = StRun;
        end
      end
      StLoad: begin
        // ld_ready is high for the whole state, so ld_valid alone marks a beat
        if (ld_valid) begin
          wr_en_d   = 1'b1;
          wr_addr_d = cnt_q;
          wr_data_d = ld_data;
          cnt_d     = cnt_q + 1'b1;
          if (cnt_q == LastAddr) begin
            loaded_d = 1'b1;
            state_d  = StIdle;
          end
        end
      end
      StRun: begin
        if (run_en) begin
          acc_d        = acc_q + freq_word;
          rd_addr_d    = ADDR_WIDTH'(phase >> (PHASE_WIDTH - ADDR_WIDTH));
          addr_vld_d   = 1'b1;
          sample_vld_d = addr_vld_q;
          if (addr_vld_q) sample_d = lut_rd_data;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      loaded_q     <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      acc_q        <= '0;
      rd_addr_q    <= '0;
      addr_vld_q   <= 1'b0;
      sample_q     <= '0;
      sample_vld_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      loaded_q     <= loaded_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      acc_q        <= acc_d;
      rd_addr_q    <= rd_addr_d;
      addr_vld_q   <= addr_vld_d;
      sample_q     <= sample_d;
      sample_vld_q <= sample_vld_d;
    end
  end

  assign ld_ready     = (state_q == StLoad);
  assign busy         = (state_q != StIdle);
  assign lut_loaded   = loaded_q;
  assign lut_wr_en    = wr_en_q;
  assign lut_wr_addr  = wr_addr_q;
  assign lut_wr_data  = wr_data_q;
  assign lut_rd_addr  = rd_addr_q;
  assign sample_out   = sample_q;
  assign sample_valid = sample_vld_q;

endmodule

// File: tb/tb_sin_lut_nco_ctrl.sv
// Directed bench for sin_lut_nco_ctrl with a 16-entry behavioural LUT.
module tb_sin_lut_nco_ctrl;

  localparam int Aw = 4;
  localparam int Dw = 16;
  localparam int Pw = 8;
`ifdef SIN_LUT_CTRL_PHASE_OFFSET_EN
  localparam int Off = 8'h40;
`else
  localparam int Off = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ld_start = 1'b0;
  logic          ld_valid = 1'b0;
  logic [Dw-1:0] ld_data = '0;
  logic          ld_ready;
  logic          lut_loaded;
  logic          run_en = 1'b0;
  logic [Pw-1:0] freq_word = '0;
  logic [Pw-1:0] phase_offset = '0;
  logic          lut_wr_en;
  logic [Aw-1:0] lut_wr_addr;
  logic [Dw-1:0] lut_wr_data;
  logic [Aw-1:0] lut_rd_addr;
  logic [Dw-1:0] lut_rd_data;
  logic [Dw-1:0] sample_out;
  logic          sample_valid;
  logic          busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [Dw-1:0] lut_mem [16];

  always #5 clk = ~clk;

  always @(posedge clk) if (lut_wr_en) lut_mem[lut_wr_addr] <= lut_wr_data;
  assign lut_rd_data = lut_mem[lut_rd_addr];

  sin_lut_nco_ctrl #(
    .NUM_ENTRY  (16),
    .ADDR_WIDTH (Aw),
    .DATA_WIDTH (Dw),
    .PHASE_WIDTH(Pw)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .ld_start    (ld_start),
    .ld_valid    (ld_valid),
    .ld_data     (ld_data),
    .ld_ready    (ld_ready),
    .lut_loaded  (lut_loaded),
    .run_en      (run_en),
    .freq_word   (freq_word),
`ifdef SIN_LUT_CTRL_PHASE_OFFSET_EN
    .phase_offset(phase_offset),
`endif
    .lut_wr_en   (lut_wr_en),
    .lut_wr_addr (lut_wr_addr),
    .lut_wr_data (lut_wr_data),
    .lut_rd_addr (lut_rd_addr),
    .lut_rd_data (lut_rd_data),
    .sample_out  (sample_out),
    .sample_valid(sample_valid),
    .busy        (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_ld_ready", 32'(ld_ready), 0);
    check_eq("rst_lut_loaded", 32'(lut_loaded), 0);
    check_eq("rst_wr_en", 32'(lut_wr_en), 0);
    check_eq("rst_wr_addr", 32'(lut_wr_addr), 0);
    check_eq("rst_wr_data", 32'(lut_wr_data), 0);
    check_eq("rst_rd_addr", 32'(lut_rd_addr), 0);
    check_eq("rst_sample_out", 32'(sample_out), 0);
    check_eq("rst_sample_valid", 32'(sample_valid), 0);
    check_eq("rst_busy", 32'(busy), 0);
  endtask

  // Streams n_beats samples 16'h1000+i; with gaps, ld_valid drops every third cycle.
  task automatic load_table(input int n_beats, input bit gaps, output int n_wr);
    int i = 0;
    int cyc = 0;
    n_wr = 0;
    ld_start = 1'b1;
    @(negedge clk);
    ld_start = 1'b0;
    check_eq("load_entry_loaded", 32'(lut_loaded), 0);
    check_eq("load_entry_ready", 32'(ld_ready), 1);
    while (i < n_beats && cyc < 200) begin
      if (lut_wr_en) begin
        check_eq("wr_addr", 32'(lut_wr_addr), 32'(n_wr));
        check_eq("wr_data", 32'(lut_wr_data), 32'(16'h1000 + n_wr));
        n_wr++;
      end
      ld_valid = gaps ? (cyc % 3 != 2) : 1'b1;
      ld_data  = 16'(16'h1000 + i);
      if (ld_valid && ld_ready) i++;
      cyc++;
      @(negedge clk);
    end
    ld_valid = 1'b0;
    check_eq("load_beats", 32'(i), 32'(n_beats));
    if (lut_wr_en) begin
      check_eq("wr_addr", 32'(lut_wr_addr), 32'(n_wr));
      check_eq("wr_data", 32'(lut_wr_data), 32'(16'h1000 + n_wr));
      n_wr++;
    end
  endtask

  // Expected address for step k: top 4 bits of (k*fw + off) mod 256; sample = table[previous addr].
  task automatic run_nco(input logic [7:0] fw, input int off, input int steps);
    int exp_a;
    int prev = 0;
    freq_word    = fw;
    phase_offset = 8'(off);
    run_en       = 1'b1;
    @(negedge clk);
    check_eq("run_busy", 32'(busy), 1);
    @(negedge clk);
    for (int k = 0; k < steps; k++) begin
      exp_a = ((k * int'(fw) + off) % 256) >> 4;
      check_eq("rd_addr", 32'(lut_rd_addr), 32'(exp_a));
      if (k == 0) begin
        check_eq("first_valid", 32'(sample_valid), 0);
      end else begin
        check_eq("sample_valid", 32'(sample_valid), 1);
        check_eq("sample_out", 32'(sample_out), 32'(16'h1000 + prev));
      end
      prev = exp_a;
      @(negedge clk);
    end
    run_en = 1'b0;
    @(negedge clk);
    check_eq("stop_valid", 32'(sample_valid), 0);
    check_eq("stop_busy", 32'(busy), 0);
    check_eq("stop_hold", 32'(sample_out), 32'(16'h1000 + prev));
  endtask

  initial begin
    int n_wr;
    repeat (2) @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    @(negedge clk);

    // Run request without a loaded table must stay idle
    run_en = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check_eq("noload_busy", 32'(busy), 0);
      check_eq("noload_valid", 32'(sample_valid), 0);
    end
    run_en = 1'b0;
    @(negedge clk);

    load_table(16, 1'b1, n_wr);
    check_eq("load_writes", 32'(n_wr), 16);
    check_eq("load_done", 32'(lut_loaded), 1);
    check_eq("load_ready_low", 32'(ld_ready), 0);
    check_eq("load_busy_low", 32'(busy), 0);
    @(negedge clk);
    check_eq("load_no_extra_wr", 32'(lut_wr_en), 0);

    run_nco(8'h10, 0, 18);
    run_nco(8'h08, 0, 10);

    // Reset in the middle of a load, then reload from address 0
    load_table(7, 1'b0, n_wr);
    check_eq("partial_writes", 32'(n_wr), 7);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    @(negedge clk);
    load_table(16, 1'b0, n_wr);
    check_eq("reload_writes", 32'(n_wr), 16);
    check_eq("reload_done", 32'(lut_loaded), 1);
    @(negedge clk);

    run_nco(8'h10, Off, 4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
